// File: rtl/jtkcpu_pkg.sv
// jtkcpu_pkg -- shared constants and helpers for the jtkcpu register file.
//   Register-select codes (opnd0_sel / wr_sel), push/pull postbyte bit
//   indices, CC flag bit indices, CC reset value, stack sequencer states
//   and the mask-scanning helper functions.
package jtkcpu_pkg;

    // Register-select codes
    localparam logic [2:0] SEL_A  = 3'd0;
    localparam logic [2:0] SEL_B  = 3'd1;
    localparam logic [2:0] SEL_D  = 3'd2;
    localparam logic [2:0] SEL_X  = 3'd3;
    localparam logic [2:0] SEL_Y  = 3'd4;
    localparam logic [2:0] SEL_U  = 3'd5;
    localparam logic [2:0] SEL_S  = 3'd6;
    localparam logic [2:0] SEL_DP = 3'd7;

    // Push/pull postbyte bit indices
    localparam logic [2:0] MSK_CC = 3'd0;
    localparam logic [2:0] MSK_A  = 3'd1;
    localparam logic [2:0] MSK_B  = 3'd2;
    localparam logic [2:0] MSK_DP = 3'd3;
    localparam logic [2:0] MSK_X  = 3'd4;
    localparam logic [2:0] MSK_Y  = 3'd5;
    localparam logic [2:0] MSK_SP = 3'd6;
    localparam logic [2:0] MSK_PC = 3'd7;

    // CC flag bit indices, ordered {E,F,H,I,N,Z,V,C}
    localparam int CC_C = 0;
    localparam int CC_V = 1;
    localparam int CC_Z = 2;
    localparam int CC_N = 3;
    localparam int CC_I = 4;
    localparam int CC_H = 5;
    localparam int CC_F = 6;
    localparam int CC_E = 7;

    // F and I set out of reset
    localparam logic [7:0] CC_RST = 8'h50;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEL  = 2'd1,
        ST_XFER = 2'd2
    } stk_state_t;

    // Mask bits 4..7 (X, Y, U/S, PC) are 16-bit registers
    function automatic logic is_wide(input logic [2:0] idx);
        is_wide = idx[2];
    endfunction

    // Highest set bit (push order); 0 when the mask is empty
    function automatic logic [2:0] msb_idx(input logic [7:0] m);
        msb_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) msb_idx = 3'(i);
        end
    endfunction

    // Lowest set bit (pull order); 0 when the mask is empty
    function automatic logic [2:0] lsb_idx(input logic [7:0] m);
        lsb_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) lsb_idx = 3'(i);
        end
    endfunction

endpackage

// File: rtl/jtkcpu_stack.sv
// jtkcpu_stack -- push/pull sequencer for the jtkcpu register file.
//   clk, rst, cen           : clock, async active-high reset, clock enable
//   i_psh, i_pul, i_use_u   : start pulses and pointer choice (1 = U)
//   i_mask                  : postbyte, bit 7 PC ... bit 0 CC
//   i_s, i_u, i_pc, i_x, i_y, i_a, i_b, i_dp, i_cc : register values to push
//   o_addr, o_dout, o_we, o_req, i_din, i_ack      : memory bus
//   o_busy                  : sequencer active
//   o_ld, o_ld_bit, o_ld_hi, o_ld_data : pulled byte strobe for the register file
//   o_sp_we, o_sp_u, o_sp_val          : pointer write-back strobe
module jtkcpu_stack
    import jtkcpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        i_psh,
    input  logic        i_pul,
    input  logic        i_use_u,
    input  logic [7:0]  i_mask,
    input  logic [15:0] i_s,
    input  logic [15:0] i_u,
    input  logic [15:0] i_pc,
    input  logic [15:0] i_x,
    input  logic [15:0] i_y,
    input  logic [7:0]  i_a,
    input  logic [7:0]  i_b,
    input  logic [7:0]  i_dp,
    input  logic [7:0]  i_cc,
    output logic [15:0] o_addr,
    output logic [7:0]  o_dout,
    output logic        o_we,
    output logic        o_req,
    input  logic [7:0]  i_din,
    input  logic        i_ack,
    output logic        o_busy,
    output logic        o_ld,
    output logic        o_ld_hi,
    output logic [2:0]  o_ld_bit,
    output logic [7:0]  o_ld_data,
    output logic        o_sp_we,
    output logic        o_sp_u,
    output logic [15:0] o_sp_val
);

    stk_state_t  r_state;
    stk_state_t  w_state_nxt;
    logic [7:0]  r_mask;
    logic [2:0]  r_bit;
    logic        r_second;     // second byte of a 16-bit register
    logic        r_push;
    logic        r_use_u;
    logic [15:0] r_ptr;
    logic [15:0] r_addr;
    logic [7:0]  r_dout;
    logic        r_we;
    logic        r_req;

    logic [2:0]  w_sel_bit;
    logic [15:0] w_val16;
    logic [7:0]  w_push_byte;
    logic [7:0]  w_mask_left;
    logic        w_last;
    logic        w_start;

    assign w_start = (i_psh || i_pul) && (i_mask != 8'd0);

    // Byte selection and completion detection for the current transfer
    always_comb begin
        w_sel_bit = r_second ? r_bit : (r_push ? msb_idx(r_mask) : lsb_idx(r_mask));
        case (w_sel_bit)
            MSK_PC:  w_val16 = i_pc;
            MSK_SP:  w_val16 = r_use_u ? i_s : i_u;   // the non-selected pointer
            MSK_Y:   w_val16 = i_y;
            MSK_X:   w_val16 = i_x;
            MSK_DP:  w_val16 = {8'd0, i_dp};
            MSK_B:   w_val16 = {8'd0, i_b};
            MSK_A:   w_val16 = {8'd0, i_a};
            default: w_val16 = {8'd0, i_cc};
        endcase
        // push stores low byte first (at the higher address)
        w_push_byte = r_second ? w_val16[15:8] : w_val16[7:0];
        w_mask_left = r_mask & ~(8'd1 << r_bit);
        w_last      = !(is_wide(r_bit) && !r_second) && (w_mask_left == 8'd0);
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) w_state_nxt = ST_SEL;
                else         w_state_nxt = ST_IDLE;
            end
            ST_SEL:  w_state_nxt = ST_XFER;
            ST_XFER: begin
                if (i_ack) w_state_nxt = w_last ? ST_IDLE : ST_SEL;
                else       w_state_nxt = ST_XFER;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      r_state <= ST_IDLE;
        else if (cen) r_state <= w_state_nxt;
    end

    // Sequencer datapath: mask scan, pointer and bus registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask   <= 8'd0;
            r_bit    <= 3'd0;
            r_second <= 1'b0;
            r_push   <= 1'b0;
            r_use_u  <= 1'b0;
            r_ptr    <= 16'd0;
            r_addr   <= 16'd0;
            r_dout   <= 8'd0;
            r_we     <= 1'b0;
            r_req    <= 1'b0;
        end else if (cen) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_push   <= i_psh;      // psh wins over pul
                        r_mask   <= i_mask;
                        r_use_u  <= i_use_u;
                        r_ptr    <= i_use_u ? i_u : i_s;
                        r_second <= 1'b0;
                    end
                end
                ST_SEL: begin
                    r_bit <= w_sel_bit;
                    r_req <= 1'b1;
                    r_we  <= r_push;
                    if (r_push) begin
                        r_ptr  <= r_ptr - 16'd1;
                        r_addr <= r_ptr - 16'd1;
                        r_dout <= w_push_byte;
                    end else begin
                        r_addr <= r_ptr;
                        r_dout <= 8'd0;
                    end
                end
                ST_XFER: begin
                    if (i_ack) begin
                        r_req <= 1'b0;
                        r_we  <= 1'b0;
                        if (!r_push) r_ptr <= r_ptr + 16'd1;
                        if (is_wide(r_bit) && !r_second) begin
                            r_second <= 1'b1;
                        end else begin
                            r_second <= 1'b0;
                            r_mask   <= w_mask_left;
                        end
                    end
                end
                default: r_req <= 1'b0;
            endcase
        end
    end

    assign o_addr    = r_addr;
    assign o_dout    = r_dout;
    assign o_we      = r_we;
    assign o_req     = r_req;
    assign o_busy    = (r_state != ST_IDLE);
    assign o_ld      = cen && (r_state == ST_XFER) && i_ack && !r_push;
    assign o_ld_bit  = r_bit;
    assign o_ld_hi   = is_wide(r_bit) && !r_second;   // pull reads high byte first
    assign o_ld_data = i_din;
    assign o_sp_we   = cen && (((r_state == ST_SEL) && r_push) || o_ld);
    assign o_sp_u    = r_use_u;
    assign o_sp_val  = r_push ? (r_ptr - 16'd1) : (r_ptr + 16'd1);

endmodule

// File: rtl/jtkcpu_regs.sv
// jtkcpu_regs -- register file (A, B, DP, X, Y, U, S, CC) with stack
//   push/pull sequencer.
//   rst, clk, cen            : async active-high reset, clock, clock enable
//   opnd0_sel / opnd0        : combinational ALU read port (8-bit zero-extended)
//   wr_sel, wr_en, rslt      : ALU write-back (D writes A:B)
//   rslt_hi, hi_we           : LMUL pair write Y=rslt, X=rslt_hi
//   cc_in, cc_we, cc         : flag register
//   psh, pul, use_u, mask    : stack sequencer start
//   pc_in, pc_out, pc_we     : PC push source / pulled PC
//   addr, dout, din, mem_we, mem_req, mem_ack : memory bus
//   busy                     : sequencer active
// Build option: define JTKCPU_LMUL_EN to enable the hi_we path.
module jtkcpu_regs
    import jtkcpu_pkg::*;
(
    input  logic        rst,
    input  logic        clk,
    input  logic        cen,
    input  logic [2:0]  opnd0_sel,
    output logic [15:0] opnd0,
    input  logic [2:0]  wr_sel,
    input  logic        wr_en,
    input  logic [15:0] rslt,
    input  logic [15:0] rslt_hi,
    input  logic        hi_we,
    input  logic [7:0]  cc_in,
    input  logic        cc_we,
    output logic [7:0]  cc,
    input  logic        psh,
    input  logic        pul,
    input  logic        use_u,
    input  logic [7:0]  mask,
    input  logic [15:0] pc_in,
    output logic [15:0] pc_out,
    output logic        pc_we,
    output logic [15:0] addr,
    output logic [7:0]  dout,
    input  logic [7:0]  din,
    output logic        mem_we,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic        busy
);

    logic [7:0]  r_a, r_b, r_dp, r_cc;
    logic [15:0] r_x, r_y, r_u, r_s, r_pc_out;
    logic        r_pc_we;

    logic        w_busy;
    logic        w_ld, w_ld_hi, w_sp_we, w_sp_u;
    logic [2:0]  w_ld_bit;
    logic [7:0]  w_ld_data;
    logic [15:0] w_sp_val;
    logic        w_lmul;

`ifdef JTKCPU_LMUL_EN
    assign w_lmul = hi_we && !w_busy;
`else
    assign w_lmul = 1'b0;
    logic  w_unused;
    assign w_unused = ^{hi_we, rslt_hi};
`endif

    jtkcpu_stack u_stack (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .i_psh     (psh),
        .i_pul     (pul),
        .i_use_u   (use_u),
        .i_mask    (mask),
        .i_s       (r_s),
        .i_u       (r_u),
        .i_pc      (pc_in),
        .i_x       (r_x),
        .i_y       (r_y),
        .i_a       (r_a),
        .i_b       (r_b),
        .i_dp      (r_dp),
        .i_cc      (r_cc),
        .o_addr    (addr),
        .o_dout    (dout),
        .o_we      (mem_we),
        .o_req     (mem_req),
        .i_din     (din),
        .i_ack     (mem_ack),
        .o_busy    (w_busy),
        .o_ld      (w_ld),
        .o_ld_hi   (w_ld_hi),
        .o_ld_bit  (w_ld_bit),
        .o_ld_data (w_ld_data),
        .o_sp_we   (w_sp_we),
        .o_sp_u    (w_sp_u),
        .o_sp_val  (w_sp_val)
    );

    // ALU read port
    always_comb begin
        case (opnd0_sel)
            SEL_A:   opnd0 = {8'd0, r_a};
            SEL_B:   opnd0 = {8'd0, r_b};
            SEL_D:   opnd0 = {r_a, r_b};
            SEL_X:   opnd0 = r_x;
            SEL_Y:   opnd0 = r_y;
            SEL_U:   opnd0 = r_u;
            SEL_S:   opnd0 = r_s;
            default: opnd0 = {8'd0, r_dp};
        endcase
    end

    // Register updates from the ALU, the LMUL pair and the stack sequencer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= 8'd0;
            r_b      <= 8'd0;
            r_dp     <= 8'd0;
            r_cc     <= CC_RST;
            r_x      <= 16'd0;
            r_y      <= 16'd0;
            r_u      <= 16'd0;
            r_s      <= 16'd0;
            r_pc_out <= 16'd0;
            r_pc_we  <= 1'b0;
        end else if (cen) begin
            r_pc_we <= 1'b0;
            if (wr_en && !w_busy) begin
                case (wr_sel)
                    SEL_A:   r_a <= rslt[7:0];
                    SEL_B:   r_b <= rslt[7:0];
                    SEL_D: begin
                        r_a <= rslt[15:8];
                        r_b <= rslt[7:0];
                    end
                    SEL_X:   if (!w_lmul) r_x <= rslt;
                    SEL_Y:   if (!w_lmul) r_y <= rslt;
                    SEL_U:   r_u <= rslt;
                    SEL_S:   r_s <= rslt;
                    default: r_dp <= rslt[7:0];
                endcase
            end
            if (w_lmul) begin
                r_y <= rslt;
                r_x <= rslt_hi;
            end
            // a pulled CC byte beats the ALU flags
            if (w_ld && (w_ld_bit == MSK_CC)) r_cc <= w_ld_data;
            else if (cc_we)                   r_cc <= cc_in;
            if (w_ld) begin
                case (w_ld_bit)
                    MSK_A:  r_a  <= w_ld_data;
                    MSK_B:  r_b  <= w_ld_data;
                    MSK_DP: r_dp <= w_ld_data;
                    MSK_X: begin
                        if (w_ld_hi) r_x[15:8] <= w_ld_data;
                        else         r_x[7:0]  <= w_ld_data;
                    end
                    MSK_Y: begin
                        if (w_ld_hi) r_y[15:8] <= w_ld_data;
                        else         r_y[7:0]  <= w_ld_data;
                    end
                    MSK_SP: begin
                        // restores the non-selected pointer
                        if (w_sp_u) begin
                            if (w_ld_hi) r_s[15:8] <= w_ld_data;
                            else         r_s[7:0]  <= w_ld_data;
                        end else begin
                            if (w_ld_hi) r_u[15:8] <= w_ld_data;
                            else         r_u[7:0]  <= w_ld_data;
                        end
                    end
                    MSK_PC: begin
                        if (w_ld_hi) begin
                            r_pc_out[15:8] <= w_ld_data;
                        end else begin
                            r_pc_out[7:0] <= w_ld_data;
                            r_pc_we       <= 1'b1;
                        end
                    end
                    default: ;  // CC handled above
                endcase
            end
            if (w_sp_we) begin
                if (w_sp_u) r_u <= w_sp_val;
                else        r_s <= w_sp_val;
            end
        end
    end

    assign cc     = r_cc;
    assign pc_out = r_pc_out;
    assign pc_we  = r_pc_we;
    assign busy   = w_busy;

endmodule

// File: tb/tb_jtkcpu_regs.sv
module tb_jtkcpu_regs;

    logic        rst, clk, cen;
    logic [2:0]  opnd0_sel, wr_sel;
    logic [15:0] opnd0, rslt, rslt_hi, pc_in, pc_out, addr;
    logic        wr_en, hi_we, cc_we, psh, pul, use_u, pc_we;
    logic [7:0]  cc_in, cc, mask, dout, din;
    logic        mem_we, mem_req, mem_ack, busy;

    logic        ack_auto, ack_man;
    logic [7:0]  mem [0:65535];
    logic [15:0] wlog_a [$];
    logic [7:0]  wlog_d [$];
    int          pcwe_cnt = 0;
    logic [15:0] pc_seen = 16'd0;
    int          checks = 0;
    int          failures = 0;
    logic [15:0] v;

    jtkcpu_regs dut (
        .rst(rst), .clk(clk), .cen(cen),
        .opnd0_sel(opnd0_sel), .opnd0(opnd0),
        .wr_sel(wr_sel), .wr_en(wr_en), .rslt(rslt),
        .rslt_hi(rslt_hi), .hi_we(hi_we),
        .cc_in(cc_in), .cc_we(cc_we), .cc(cc),
        .psh(psh), .pul(pul), .use_u(use_u), .mask(mask),
        .pc_in(pc_in), .pc_out(pc_out), .pc_we(pc_we),
        .addr(addr), .dout(dout), .din(din),
        .mem_we(mem_we), .mem_req(mem_req), .mem_ack(mem_ack),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_ack = ack_auto ? mem_req : ack_man;
    assign din     = mem[addr];

    // Memory model and bus/PC monitors
    always @(posedge clk) begin
        if (cen && mem_req && mem_ack && mem_we) begin
            mem[addr] <= dout;
            wlog_a.push_back(addr);
            wlog_d.push_back(dout);
        end
        if (cen && pc_we) begin
            pcwe_cnt <= pcwe_cnt + 1;
            pc_seen  <= pc_out;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] sel, input logic [15:0] val);
        wr_sel = sel; rslt = val; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [2:0] sel, output logic [15:0] val);
        opnd0_sel = sel;
        #1;
        val = opnd0;
    endtask

    task automatic start(input logic p, input logic q, input logic [7:0] m);
        psh = p; pul = q; mask = m;
        tick();
        psh = 1'b0; pul = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; cen = 1'b1; opnd0_sel = 3'd0; wr_sel = 3'd0; wr_en = 1'b0;
        rslt = 16'd0; rslt_hi = 16'd0; hi_we = 1'b0; cc_in = 8'd0; cc_we = 1'b0;
        psh = 1'b0; pul = 1'b0; use_u = 1'b0; mask = 8'd0; pc_in = 16'd0;
        ack_auto = 1'b1; ack_man = 1'b0;
        tick(); tick();
        // reset state
        check("rst_cc", {24'd0, cc}, 32'h50);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_addr", {16'd0, addr}, 32'd0);
        rd(3'd6, v); check("rst_s", {16'd0, v}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // ALU writes
        wr(3'd2, 16'h1122);
        rd(3'd0, v); check("wr_a", {16'd0, v}, 32'h0011);
        rd(3'd1, v); check("wr_b", {16'd0, v}, 32'h0022);
        rd(3'd2, v); check("rd_d", {16'd0, v}, 32'h1122);
        wr(3'd6, 16'h1000);

        // push PC, B, A onto S
        pc_in = 16'h1234; use_u = 1'b0;
        start(1'b1, 1'b0, 8'h86);
        check("push_busy", {31'd0, busy}, 32'd1);
        wait_idle("push_done");
        check("push_cnt", wlog_a.size(), 32'd4);
        if (wlog_a.size() == 4) begin
            check("push_a0", {16'd0, wlog_a[0]}, 32'h0FFF); check("push_d0", {24'd0, wlog_d[0]}, 32'h34);
            check("push_a1", {16'd0, wlog_a[1]}, 32'h0FFE); check("push_d1", {24'd0, wlog_d[1]}, 32'h12);
            check("push_a2", {16'd0, wlog_a[2]}, 32'h0FFD); check("push_d2", {24'd0, wlog_d[2]}, 32'h22);
            check("push_a3", {16'd0, wlog_a[3]}, 32'h0FFC); check("push_d3", {24'd0, wlog_d[3]}, 32'h11);
        end
        rd(3'd6, v); check("push_s", {16'd0, v}, 32'h0FFC);

        // pull the same frame back
        wr(3'd2, 16'h0000);
        start(1'b0, 1'b1, 8'h86);
        wait_idle("pull_done");
        tick();
        rd(3'd0, v); check("pull_a", {16'd0, v}, 32'h0011);
        rd(3'd1, v); check("pull_b", {16'd0, v}, 32'h0022);
        rd(3'd6, v); check("pull_s", {16'd0, v}, 32'h1000);
        check("pull_pc", {16'd0, pc_out}, 32'h1234);
        check("pull_pcwe_cnt", pcwe_cnt, 32'd1);
        check("pull_pc_seen", {16'd0, pc_seen}, 32'h1234);
        check("pull_pcwe_low", {31'd0, pc_we}, 32'd0);

        // pointer wrap with CC push
        wr(3'd6, 16'h0000);
        cc_in = 8'hA5; cc_we = 1'b1; tick(); cc_we = 1'b0;
        check("cc_load", {24'd0, cc}, 32'hA5);
        start(1'b1, 1'b0, 8'h01);
        wait_idle("wrap_done");
        check("wrap_mem", {24'd0, mem[16'hFFFF]}, 32'hA5);
        rd(3'd6, v); check("wrap_s", {16'd0, v}, 32'hFFFF);

        // empty mask: no activity
        start(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            check("empty_busy", {31'd0, busy}, 32'd0);
            tick();
        end
        check("empty_writes", wlog_a.size(), 32'd5);

        // LMUL pair against a simultaneous X write
        wr_sel = 3'd3; wr_en = 1'b1; rslt = 16'h5678; rslt_hi = 16'h1234; hi_we = 1'b1;
        tick();
        wr_en = 1'b0; hi_we = 1'b0;
`ifdef JTKCPU_LMUL_EN
        rd(3'd4, v); check("lmul_y", {16'd0, v}, 32'h5678);
        rd(3'd3, v); check("lmul_x", {16'd0, v}, 32'h1234);
`else
        rd(3'd4, v); check("nolmul_y", {16'd0, v}, 32'h0000);
        rd(3'd3, v); check("nolmul_x", {16'd0, v}, 32'h5678);
`endif

        // wait states: bus held stable until ack
        wr(3'd0, 16'h003C);
        wr(3'd6, 16'h2000);
        ack_auto = 1'b0; ack_man = 1'b0;
        start(1'b1, 1'b0, 8'h02);
        for (int n = 0; n < 10 && !mem_req; n++) tick();
        check("ws_req", {31'd0, mem_req}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("ws_addr", {16'd0, addr}, 32'h1FFF);
            check("ws_dout", {24'd0, dout}, 32'h3C);
            check("ws_hold", {30'd0, mem_req, mem_we}, 32'd3);
            tick();
        end
        ack_man = 1'b1; tick(); ack_man = 1'b0;
        check("ws_busy", {31'd0, busy}, 32'd0);
        check("ws_mem", {24'd0, mem[16'h1FFF]}, 32'h3C);

        // clock enable low: no state change
        cen = 1'b0;
        wr(3'd0, 16'h0077);
        rd(3'd0, v); check("cen_hold", {16'd0, v}, 32'h003C);
        cen = 1'b1;

        // reset in the middle of a push
        wr(3'd6, 16'h3000);
        start(1'b1, 1'b0, 8'hFF);
        for (int n = 0; n < 10 && !mem_req; n++) tick();
        check("rm_req", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        #1;
        check("rm_cc", {24'd0, cc}, 32'h50);
        check("rm_busy", {31'd0, busy}, 32'd0);
        check("rm_req_low", {31'd0, mem_req}, 32'd0);
        check("rm_we_low", {31'd0, mem_we}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
